// File: rtl/wave_addr_gen.sv
// Phase-accumulator address generator for a 1024-entry waveform table, with a
// programmable sample-rate divider and a duty select that only changes on phase wrap.
module wave_addr_gen #(
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 10,
    parameter int DIV_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_restart,
    input  logic [ACC_W-1:0]  i_fcw,
    input  logic [DIV_W-1:0]  i_div,
    input  logic [3:0]        i_sel_req,
    output logic [ADDR_W-1:0] o_addr,
    output logic [3:0]        o_sel,
    output logic              o_valid,
    output logic              o_wrap
);

    localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [3:0]       pend;
    logic [ACC_W:0]   sum;
    logic             tick;
    logic             legal;

    assign legal = (i_sel_req <= 4'd10);
    // >= keeps the divider from running away if i_div is lowered mid-count
    assign tick  = i_en && (cnt >= i_div);
    assign sum   = {1'b0, acc} + {1'b0, i_fcw};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt     <= '0;
            acc     <= '0;
            pend    <= '0;
            o_addr  <= '0;
            o_sel   <= '0;
            o_valid <= 1'b0;
            o_wrap  <= 1'b0;
        end else begin
            if (legal)
                pend <= i_sel_req;
            if (i_restart) begin
                cnt     <= '0;
                acc     <= '0;
                o_addr  <= '0;
                o_valid <= 1'b0;
                o_wrap  <= 1'b0;
                o_sel   <= legal ? i_sel_req : pend;
            end else begin
                o_valid <= tick;
                o_wrap  <= tick & sum[ACC_W];
                if (i_en)
                    cnt <= tick ? '0 : cnt + CNT_ONE;
                if (tick) begin
                    acc    <= sum[ACC_W-1:0];
                    o_addr <= sum[ACC_W-1 -: ADDR_W];
                    // duty only switches at the start of a new waveform period
                    if (sum[ACC_W])
                        o_sel <= pend;
                end
            end
        end
    end

endmodule

// File: tb/tb_wave_addr_gen.sv
// Randomized self-checking bench for wave_addr_gen against a phase/enabled-cycle reference model.
module tb_wave_addr_gen;

    localparam int ACC_W  = 24;
    localparam int ADDR_W = 10;
    localparam int DIV_W  = 16;
    localparam longint MOD = longint'(1) << ACC_W;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b0;
    logic              i_en = 1'b0;
    logic              i_restart = 1'b0;
    logic [ACC_W-1:0]  i_fcw = '0;
    logic [DIV_W-1:0]  i_div = '0;
    logic [3:0]        i_sel_req = '0;
    logic [ADDR_W-1:0] o_addr;
    logic [3:0]        o_sel;
    logic              o_valid;
    logic              o_wrap;

    int n_cmp = 0;
    int n_bad = 0;

    wave_addr_gen #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_restart(i_restart),
        .i_fcw(i_fcw), .i_div(i_div), .i_sel_req(i_sel_req),
        .o_addr(o_addr), .o_sel(o_sel), .o_valid(o_valid), .o_wrap(o_wrap)
    );

    always #5 i_clk = ~i_clk;

    // Reference: total phase and enabled cycles since reset/restart; a tick falls on
    // every (div+1)-th enabled cycle.
    longint            m_phase;
    int                m_en_cnt;
    logic [3:0]        m_pend;
    logic [ADDR_W-1:0] exp_addr;
    logic [3:0]        exp_sel;
    logic              exp_valid;
    logic              exp_wrap;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_phase = 0; m_en_cnt = 0; m_pend = 0;
            exp_addr = 0; exp_sel = 0; exp_valid = 0; exp_wrap = 0;
        end else begin
            if (i_restart) begin
                m_phase = 0; m_en_cnt = 0;
                exp_addr = 0; exp_valid = 0; exp_wrap = 0;
                exp_sel = (i_sel_req <= 10) ? i_sel_req : m_pend;
            end else begin
                exp_valid = 0; exp_wrap = 0;
                if (i_en) begin
                    m_en_cnt++;
                    if (m_en_cnt % (int'(i_div) + 1) == 0) begin
                        longint s;
                        s = m_phase + longint'(i_fcw);
                        exp_wrap = (s >= MOD);
                        m_phase = s % MOD;
                        exp_addr = ADDR_W'(m_phase >> (ACC_W - ADDR_W));
                        exp_valid = 1;
                        if (exp_wrap) exp_sel = m_pend;
                    end
                end
            end
            if (i_sel_req <= 10) m_pend = i_sel_req;
        end
    end

    task automatic test_reset();
        i_rst = 1'b1;
        #3;
        n_cmp++;
        if ({o_addr, o_sel, o_valid, o_wrap} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset: got %h want 0000", {o_addr, o_sel, o_valid, o_wrap});
        end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
    endtask

    task automatic test_sweep();
        i_en = 1; i_div = 0; i_fcw = 24'h004000;
        for (int k = 1; k <= 1030; k++) begin
            @(posedge i_clk); #1;
            n_cmp++;
            if ({o_addr, o_sel, o_valid, o_wrap} !== {exp_addr, exp_sel, exp_valid, exp_wrap}) begin
                n_bad++;
                $display("FAIL sweep cyc %0d: got %h want %h", k, {o_addr, o_sel, o_valid, o_wrap},
                         {exp_addr, exp_sel, exp_valid, exp_wrap});
            end
            if (k == 5 || k == 1023 || k == 1024) begin
                n_cmp++;
                if (o_addr !== ADDR_W'(k % 1024) || o_wrap !== (k == 1024) || o_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL sweep_pt %0d: got addr=%0d wrap=%0b valid=%0b want addr=%0d wrap=%0b valid=1",
                             k, o_addr, o_wrap, o_valid, k % 1024, k == 1024);
                end
            end
        end
    endtask

    task automatic test_divided();
        int pulses;
        i_restart = 1; i_div = 3; i_fcw = 24'h004000; i_en = 1;
        @(posedge i_clk); #1;
        i_restart = 0;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge i_clk); #1;
            pulses += int'(o_valid);
            n_cmp++;
            if ({o_addr, o_sel, o_valid, o_wrap} !== {exp_addr, exp_sel, exp_valid, exp_wrap}) begin
                n_bad++;
                $display("FAIL divided cyc %0d: got %h want %h", k, {o_addr, o_sel, o_valid, o_wrap},
                         {exp_addr, exp_sel, exp_valid, exp_wrap});
            end
        end
        n_cmp++;
        if (pulses != 10 || o_addr !== 10'd10) begin
            n_bad++;
            $display("FAIL divided_rate: got pulses=%0d addr=%0d want pulses=10 addr=10", pulses, o_addr);
        end
        i_en = 0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            pulses += int'(o_valid);
        end
        n_cmp++;
        if (pulses != 0 || o_addr !== 10'd10) begin
            n_bad++;
            $display("FAIL divided_hold: got pulses=%0d addr=%0d want pulses=0 addr=10", pulses, o_addr);
        end
        i_en = 1;
    endtask

    task automatic test_duty();
        i_restart = 1; i_sel_req = 5; i_div = 0; i_fcw = 24'h100000; i_en = 1;
        @(posedge i_clk); #1;
        i_restart = 0;
        n_cmp++;
        if (o_sel !== 4'd5) begin
            n_bad++;
            $display("FAIL duty_restart: got sel=%0d want 5", o_sel);
        end
        for (int k = 1; k <= 16 + 40; k++) begin
            if (k == 6) i_sel_req = 8;
            if (k == 17) i_sel_req = 12;
            @(posedge i_clk); #1;
            n_cmp++;
            if ({o_addr, o_sel, o_valid, o_wrap} !== {exp_addr, exp_sel, exp_valid, exp_wrap}) begin
                n_bad++;
                $display("FAIL duty cyc %0d: got %h want %h", k, {o_addr, o_sel, o_valid, o_wrap},
                         {exp_addr, exp_sel, exp_valid, exp_wrap});
            end
            if (k == 15 || k == 16 || k == 56) begin
                n_cmp++;
                if (o_sel !== ((k == 15) ? 4'd5 : 4'd8)) begin
                    n_bad++;
                    $display("FAIL duty_sel cyc %0d: got %0d want %0d", k, o_sel, (k == 15) ? 5 : 8);
                end
            end
        end
    endtask

    task automatic test_fast();
        i_restart = 1; i_div = 0; i_fcw = 24'h800000; i_en = 1;
        @(posedge i_clk); #1;
        i_restart = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge i_clk); #1;
            n_cmp++;
            if (o_addr !== ((k % 2 == 1) ? 10'd512 : 10'd0) || o_wrap !== (k % 2 == 0) || o_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL fast cyc %0d: got addr=%0d wrap=%0b valid=%0b", k, o_addr, o_wrap, o_valid);
            end
        end
    endtask

    task automatic test_restart();
        i_restart = 1; i_div = 2; i_fcw = 24'h4B0000; i_en = 1; i_sel_req = 7;
        @(posedge i_clk); #1;
        i_restart = 0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) begin i_restart = 1; i_sel_req = 3; end
            @(posedge i_clk); #1;
        end
        i_restart = 0;
        n_cmp++;
        if ({o_addr, o_sel, o_valid, o_wrap} !== {10'd0, 4'd3, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL restart: got addr=%0d sel=%0d v=%0b w=%0b want 0,3,0,0", o_addr, o_sel, o_valid, o_wrap);
        end
        for (int k = 1; k <= 3; k++) begin
            @(posedge i_clk); #1;
            n_cmp++;
            if (o_valid !== (k == 3) || (k == 3 && o_addr !== 10'd300)) begin
                n_bad++;
                $display("FAIL restart_resume cyc %0d: got valid=%0b addr=%0d", k, o_valid, o_addr);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 2000; k++) begin
            i_en = ($urandom_range(0, 3) != 0);
            i_sel_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) i_fcw = ACC_W'($urandom);
            i_restart = ($urandom_range(0, 49) == 0);
            if (i_restart) i_div = DIV_W'($urandom_range(0, 5));
            @(posedge i_clk); #1;
            n_cmp++;
            if ({o_addr, o_sel, o_valid, o_wrap} !== {exp_addr, exp_sel, exp_valid, exp_wrap}) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %h want %h", k, {o_addr, o_sel, o_valid, o_wrap},
                         {exp_addr, exp_sel, exp_valid, exp_wrap});
            end
        end
        i_restart = 0;
    endtask

    task automatic test_async_reset();
        i_en = 1; i_div = 0; i_fcw = 24'h0C3501; i_sel_req = 9;
        repeat (20) @(posedge i_clk);
        #3 i_rst = 1;
        #1;
        n_cmp++;
        if ({o_addr, o_sel, o_valid, o_wrap} !== 16'h0) begin
            n_bad++;
            $display("FAIL async_reset: got %h want 0000", {o_addr, o_sel, o_valid, o_wrap});
        end
        @(posedge i_clk); #1;
        i_rst = 0; i_div = 2; i_fcw = 24'h004000;
        for (int k = 1; k <= 6; k++) begin
            @(posedge i_clk); #1;
            n_cmp++;
            if (o_valid !== (k % 3 == 0) || {o_addr, o_sel, o_valid, o_wrap} !== {exp_addr, exp_sel, exp_valid, exp_wrap}) begin
                n_bad++;
                $display("FAIL post_reset cyc %0d: got %h want %h", k, {o_addr, o_sel, o_valid, o_wrap},
                         {exp_addr, exp_sel, exp_valid, exp_wrap});
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_sweep();
        test_divided();
        test_duty();
        test_fast();
        test_restart();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
